// File: rtl/joy_pkg.sv
// Shared definitions for the DB15 joystick adapter reader: FSM states,
// frame width and the button bit positions within each 16-bit player word.
package joy_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_SHIFT_LO = 3'd2,
    ST_SHIFT_HI = 3'd3,
    ST_PUBLISH  = 3'd4
  } joy_state_t;

  localparam int JOY_BITS = 32;

  localparam int BIT_R  = 0;
  localparam int BIT_L  = 1;
  localparam int BIT_DN = 2;
  localparam int BIT_UP = 3;
  localparam int BIT_A  = 6;
  localparam int BIT_B  = 7;
  localparam int BIT_C  = 8;
  localparam int BIT_D  = 9;
  localparam int BIT_E  = 10;
  localparam int BIT_F  = 11;
  localparam int BIT_S  = 12;
  localparam int BIT_LS = 13;

endpackage

// File: rtl/joy_tick_gen.sv
// Free-running divider producing a one-cycle tick every CLK_DIV clocks;
// each tick marks one half-period of the adapter shift clock.
module joy_tick_gen #(
  parameter int CLK_DIV = 24
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign tick = (cnt_q == CNT_MAX);

endmodule

// File: rtl/joy_db15_reader.sv
// Scans a two-player DB15 adapter shift-register chain once per frame and
// publishes both 16-bit button words atomically (active-high).
module joy_db15_reader
  import joy_pkg::*;
#(
  parameter int CLK_DIV     = 24,
  parameter int FRAME_TICKS = 2000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        joy_data,
  output logic        joy_clk,
  output logic        joy_load,
  output logic [15:0] joystick1,
  output logic [15:0] joystick2,
  output logic        frame_done,
  output logic        joy_valid
);

  localparam int FW = $clog2(FRAME_TICKS);
  localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_TICKS - 1);
  localparam logic [4:0]    IDX_LAST   = 5'(JOY_BITS - 1);

  logic tick;

  joy_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .tick    (tick)
  );

  logic                sync1_q, sync2_q;
  joy_state_t          state_q, state_d;
  logic [FW-1:0]       frame_q, frame_d;
  logic [4:0]          idx_q, idx_d;
  logic [JOY_BITS-1:0] buf_q, buf_d;
  logic                joy_clk_q, joy_clk_d;
  logic                joy_load_q, joy_load_d;
  logic [15:0]         joy1_q, joy1_d;
  logic [15:0]         joy2_q, joy2_d;
  logic                done_q, done_d;
  logic                valid_q, valid_d;

  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    idx_d   = idx_q;
    buf_d   = buf_q;
    joy1_d  = joy1_q;
    joy2_d  = joy2_q;
    done_d  = 1'b0;
    valid_d = valid_q;

    // Frame counter runs in every state so the scan period is fixed.
    if (tick) frame_d = (frame_q == FRAME_LAST) ? '0 : frame_q + 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (tick && frame_q == FRAME_LAST) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (tick) begin
          state_d = ST_SHIFT_LO;
          idx_d   = '0;
        end
      end
      ST_SHIFT_LO: begin
        if (tick) begin
          buf_d[idx_q] = sync2_q;
          state_d      = ST_SHIFT_HI;
        end
      end
      ST_SHIFT_HI: begin
        if (tick) begin
          if (idx_q == IDX_LAST) state_d = ST_PUBLISH;
          else begin
            idx_d   = idx_q + 1'b1;
            state_d = ST_SHIFT_LO;
          end
        end
      end
      ST_PUBLISH: begin
        joy1_d  = ~buf_q[15:0];
        joy2_d  = ~buf_q[31:16];
        done_d  = 1'b1;
        valid_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Pins are registered from the next state so they align with state_q.
    joy_clk_d  = (state_d == ST_SHIFT_HI);
    joy_load_d = (state_d != ST_LOAD);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      state_q    <= ST_IDLE;
      frame_q    <= '0;
      idx_q      <= '0;
      buf_q      <= '0;
      joy_clk_q  <= 1'b0;
      joy_load_q <= 1'b1;
      joy1_q     <= '0;
      joy2_q     <= '0;
      done_q     <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      sync1_q    <= joy_data;
      sync2_q    <= sync1_q;
      state_q    <= state_d;
      frame_q    <= frame_d;
      idx_q      <= idx_d;
      buf_q      <= buf_d;
      joy_clk_q  <= joy_clk_d;
      joy_load_q <= joy_load_d;
      joy1_q     <= joy1_d;
      joy2_q     <= joy2_d;
      done_q     <= done_d;
      valid_q    <= valid_d;
    end
  end

  assign joy_clk    = joy_clk_q;
  assign joy_load   = joy_load_q;
  assign joystick1  = joy1_q;
  assign joystick2  = joy2_q;
  assign frame_done = done_q;
  assign joy_valid  = valid_q;

endmodule

// File: tb/tb_joy_db15_reader.sv
// Bench for joy_db15_reader: behavioural 74HC165-style adapter chain,
// table vectors, random frames against a button-level model, corner sequences.
module tb_joy_db15_reader;

  localparam int CLK_DIV     = 4;
  localparam int FRAME_TICKS = 70;
  localparam int FRAME_CLKS  = CLK_DIV * FRAME_TICKS;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        joy_data;
  logic        joy_clk, joy_load, frame_done, joy_valid;
  logic [15:0] joystick1, joystick2;

  always #5 clk = ~clk;

  joy_db15_reader #(.CLK_DIV(CLK_DIV), .FRAME_TICKS(FRAME_TICKS)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .joy_data   (joy_data),
    .joy_clk    (joy_clk),
    .joy_load   (joy_load),
    .joystick1  (joystick1),
    .joystick2  (joystick2),
    .frame_done (frame_done),
    .joy_valid  (joy_valid)
  );

  // Adapter: parallel load while joy_load low, shift on joy_clk rise, bit 0 first.
  logic [31:0] adapter_word = 32'hFFFF_FFFF;
  logic [31:0] sr = 32'hFFFF_FFFF;
  logic        jclk_prev = 1'b0;
  always @(posedge clk) begin
    if (!joy_load) sr <= adapter_word;
    else if (joy_clk && !jclk_prev) sr <= {1'b1, sr[31:1]};
    jclk_prev <= joy_clk;
  end
  assign joy_data = sr[0];

  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Pressed buttons are the inverse of the serial levels, sample k -> bit k.
  function automatic logic [31:0] pressed_of(input logic [31:0] raw);
    return ~raw;
  endfunction

  // Pin timing monitor.
  int   cyc = 0, last_fall = 0, period = 0, load_run = 0, load_len = 0;
  int   hi_run = 0, pulses = 0, pulses_last = 0, bad_width = 0;
  logic load_prev = 1'b1, clkp = 1'b0;
  always @(negedge clk) begin
    if (reset_n) begin
      cyc++;
      if (!joy_load && load_prev) begin
        period = cyc - last_fall;
        last_fall = cyc;
        pulses_last = pulses;
        pulses = 0;
        load_run = 0;
      end
      if (!joy_load) load_run++;
      else if (!load_prev) load_len = load_run;
      if (joy_clk) hi_run++;
      else if (clkp) begin
        pulses++;
        if (hi_run != CLK_DIV) bad_width++;
        hi_run = 0;
      end
      load_prev = joy_load;
      clkp = joy_clk;
    end
  end

  task automatic wait_frame(input int budget, output bit got, output bit held);
    logic [15:0] a, b;
    a = joystick1;
    b = joystick2;
    got = 1'b0;
    held = 1'b1;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      if (frame_done) got = 1'b1;
      else if (joystick1 !== a || joystick2 !== b) held = 1'b0;
    end
  endtask

  task automatic wait_shift(input int n, output bit ok);
    int   cnt;
    logic prev;
    ok = 1'b0;
    cnt = 0;
    for (int i = 0; i < 2 * FRAME_CLKS && joy_load; i++) @(negedge clk);
    if (joy_load) return;
    prev = joy_clk;
    for (int i = 0; i < 2 * FRAME_CLKS && cnt < n; i++) begin
      @(negedge clk);
      if (joy_clk && !prev) cnt++;
      prev = joy_clk;
    end
    ok = (cnt == n);
  endtask

  typedef struct packed {
    logic [31:0] raw;
    logic [15:0] j1;
    logic [15:0] j2;
  } vec_t;

  vec_t vecs[5];

  initial begin
    bit          got, held, ok;
    int          n, fd_seen, valid_seen;
    logic [31:0] r, p, old_p, word_b, word_c;

    vecs[0] = '{raw: ~{16'h0800, 16'h0005}, j1: 16'h0005, j2: 16'h0800};
    vecs[1] = '{raw: 32'hFFFF_FFFF, j1: 16'h0000, j2: 16'h0000};
    vecs[2] = '{raw: 32'hA5A5_5A5A, j1: 16'hA5A5, j2: 16'h5A5A};
    vecs[3] = '{raw: 32'h0000_0000, j1: 16'hFFFF, j2: 16'hFFFF};
    vecs[4] = '{raw: 32'h0000_FFFF, j1: 16'h0000, j2: 16'hFFFF};

    adapter_word = vecs[0].raw;
    repeat (3) @(negedge clk);
    check("reset_ctrl", {28'd0, joy_clk, joy_load, frame_done, joy_valid}, 32'h4);
    check("reset_joy", {joystick2, joystick1}, 32'h0);

    reset_n = 1'b1;
    n = 0;
    while (joy_load && n < 4 * FRAME_CLKS) begin
      @(negedge clk);
      n++;
    end
    check("first_load_delay", n, FRAME_CLKS);

    for (int i = 0; i < 5; i++) begin
      wait_frame(2 * FRAME_CLKS, got, held);
      check($sformatf("vec%0d_frame_done", i), got, 1);
      check($sformatf("vec%0d_j1", i), joystick1, vecs[i].j1);
      check($sformatf("vec%0d_j2", i), joystick2, vecs[i].j2);
      check($sformatf("vec%0d_valid", i), joy_valid, 1);
      if (i < 4) adapter_word = vecs[i + 1].raw;
      if (i == 0) begin
        @(negedge clk);
        check("frame_done_one_cycle", frame_done, 0);
      end
    end

    for (int i = 0; i < 6; i++) begin
      r = $urandom;
      adapter_word = r;
      p = pressed_of(r);
      wait_frame(2 * FRAME_CLKS, got, held);
      check($sformatf("rand%0d_frame_done", i), got, 1);
      check($sformatf("rand%0d_joy", i), {joystick2, joystick1}, p);
    end

    check("load_low_clks", load_len, CLK_DIV);
    check("clk_pulses", pulses_last, 32);
    check("clk_pulse_width_errs", bad_width, 0);
    check("load_period", period, FRAME_CLKS);

    // New input applied mid-shift must not leak into the published frame.
    old_p = p;
    word_b = 32'h1234_5678;
    word_c = 32'hCAFE_0F0F;
    adapter_word = word_b;
    wait_shift(10, ok);
    check("midshift_reached", ok, 1);
    adapter_word = word_c;
    check("midshift_old_joy", {joystick2, joystick1}, old_p);
    wait_frame(2 * FRAME_CLKS, got, held);
    check("midshift_frame_done", got, 1);
    check("midshift_held", held, 1);
    check("midshift_new_joy", {joystick2, joystick1}, pressed_of(word_b));
    wait_frame(2 * FRAME_CLKS, got, held);
    check("next_frame_joy", {joystick2, joystick1}, pressed_of(word_c));

    // Reset during bit 17 abandons the frame.
    wait_shift(17, ok);
    check("bit17_reached", ok, 1);
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("midreset_ctrl", {28'd0, joy_clk, joy_load, frame_done, joy_valid}, 32'h4);
    check("midreset_joy", {joystick2, joystick1}, 32'h0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    fd_seen = 0;
    valid_seen = 0;
    repeat (FRAME_CLKS + 20) begin
      @(negedge clk);
      if (frame_done) fd_seen++;
      if (joy_valid) valid_seen++;
    end
    check("postreset_no_frame_done", fd_seen, 0);
    check("postreset_valid_low", valid_seen, 0);
    wait_frame(2 * FRAME_CLKS, got, held);
    check("postreset_frame_done", got, 1);
    check("postreset_valid", joy_valid, 1);
    check("postreset_joy", {joystick2, joystick1}, pressed_of(word_c));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/joy_db15_reader.md
JOY_DB15_READER -- requirements
Module: joy_db15_reader

Interface
REQ-001 SHALL have parameter CLK_DIV, default 24, giving system clocks per serial half-bit tick (minimum 4).
REQ-002 SHALL have parameter FRAME_TICKS, default 2000, giving ticks per scan frame (minimum 70).
REQ-003 SHALL have port clk  input  1  system clock, 40-50 MHz; all logic is on its rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port joy_data  input  1  serial data from the adapter shift-register chain; active-low buttons; asynchronous.
REQ-006 SHALL have port joy_clk  output  1  shift clock to the adapter; idles low.
REQ-007 SHALL have port joy_load  output  1  parallel-load strobe to the adapter; active low.
REQ-008 SHALL have port joystick1  output  16  player-1 buttons, active high, layout LS FEDCBAUDLR (bit0=R ... bit11=F).
REQ-009 SHALL have port joystick2  output  16  player-2 buttons, same layout.
REQ-010 SHALL have port frame_done  output  1  one-cycle pulse when joystick1/2 update.
REQ-011 SHALL have port joy_valid  output  1  high once the first complete frame is published.

Function
REQ-012 SHALL synchronise joy_data through two flip-flops before any use.
REQ-013 SHALL generate an internal tick on one clk cycle every CLK_DIV cycles via a free-running counter.
REQ-014 SHALL run FSM states IDLE, LOAD, SHIFT_LO, SHIFT_HI, PUBLISH; all state changes except PUBLISH->IDLE occur on tick.
REQ-015 IDLE: joy_load=1, joy_clk=0; leave to LOAD when the frame tick counter reaches FRAME_TICKS-1, then clear it.
REQ-016 LOAD: joy_load=0 for exactly one tick period; then SHIFT_LO with bit index 0.
REQ-017 SHIFT_LO: joy_clk=0; on the tick ending this state, sample synchronised data into bit[index]; go to SHIFT_HI.
REQ-018 SHIFT_HI: joy_clk=1 for one tick period; on its ending tick, if index=31 go to PUBLISH, else increment index and go to SHIFT_LO.
REQ-019 Bit mapping SHALL be: sample k (0..31) is stored at position k; k<16 maps to joystick1[k], k>=16 maps to joystick2[k-16].
REQ-020 PUBLISH SHALL last exactly one clk cycle.
REQ-021 In PUBLISH, the block SHALL drive joystick1/2 with the bitwise inverse of the 32 captured bits, pulse frame_done=1, set joy_valid=1, and return to IDLE.
REQ-022 joystick1/2 SHALL be held constant between PUBLISH cycles; a partial frame SHALL never be visible.
REQ-023 The frame counter SHALL count ticks in every state, so frame period is exactly FRAME_TICKS ticks, and it SHALL wrap at FRAME_TICKS-1.
REQ-024 A floating or disconnected adapter (joy_data constantly 1) SHALL yield joystick1=joystick2=16'h0000 with joy_valid=1.
REQ-025 The index counter SHALL be 5 bits wide and SHALL never exceed 31.
REQ-026 Outputs joy_clk and joy_load SHALL be registered (glitch-free).

Reset
REQ-027 On reset_n low, outputs SHALL be forced asynchronously to: joy_clk=0, joy_load=1, joystick1=0, joystick2=0, frame_done=0, joy_valid=0.
REQ-028 On reset_n low, state=IDLE and all counters, the shift buffer and the synchronisers SHALL be cleared.
REQ-029 Reset asserted mid-frame SHALL abandon the frame; no PUBLISH occurs for it.
REQ-030 After reset release, the first LOAD SHALL start FRAME_TICKS ticks later.

Structure
REQ-031 Shared package joy_pkg SHALL hold the FSM state enum, JOY_BITS=32, and the bit-position constants for R,L,D,U,A..F,S,LS.
REQ-032 Tick generation SHALL be a sub-module joy_tick_gen (parameter CLK_DIV; ports clk, reset_n, tick).
REQ-033 The top-level SHALL instantiate one joy_db15_reader in place of the current DB15 reader, with unchanged joystick1/joystick2 wiring.

Verification
REQ-034 Adapter model with P1=16'h0005 and P2=16'h0800 pressed (active-low serial) -> after one frame joystick1=16'h0005, joystick2=16'h0800, and frame_done pulses once.
REQ-035 CLK_DIV=4, FRAME_TICKS=70 -> joy_load low for 4 clks, exactly 32 joy_clk high pulses of 4 clks each, and 280 clks between LOAD falling edges.
REQ-036 joy_data held 1 -> joystick1=joystick2=16'h0000 and joy_valid=1 after the first frame.
REQ-037 Model input changed mid-SHIFT -> outputs stay at the old frame values until PUBLISH, then show the newly sampled data.
REQ-038 reset_n pulsed low during bit 17 -> all outputs return to reset values within the same cycle, no frame_done for that frame, joy_valid=0 until the next full frame.
REQ-039 Adapter pattern 32'hA5A5_5A5A (raw) -> joystick1=16'hA5A5, joystick2=16'h5A5A, confirming the k-to-bit mapping and inversion.
